// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the binary GCD unit.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count shared factors of two, 0..W.
    function automatic int k_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational reduction step of the binary GCD algorithm.
module gcd_stein_step
    import gcd_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = 5
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  a_nxt,
    output logic [W-1:0]  b_nxt,
    output logic [KW-1:0] k_nxt,
    output logic          done,
    output logic [W-1:0]  result
);

    logic [W-1:0] w_diff_ab;
    logic [W-1:0] w_diff_ba;

    assign w_diff_ab = a - b;
    assign w_diff_ba = b - a;

    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = '0;
        if (a == '0) begin
            done   = 1'b1;
            result = b << k;
        end else if (b == '0) begin
            done   = 1'b1;
            result = a << k;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + 1'b1;
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a >= b) begin
            // odd minus odd is even, so the halving loses nothing
            a_nxt = w_diff_ab >> 1;
        end else begin
            b_nxt = w_diff_ba >> 1;
        end
    end

endmodule

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD unit with tagged valid/ready request and result ports.
module gcd_stein_unit
    import gcd_pkg::*;
#(
    parameter int W     = 16,
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     operands_bits_A,
    input  logic [W-1:0]     operands_bits_B,
    input  logic [TAG_W-1:0] operands_bits_tag,
    input  logic             operands_val,
    output logic             operands_rdy,
    output logic [W-1:0]     result_bits_data,
    output logic [TAG_W-1:0] result_bits_tag,
    output logic [CNT_W-1:0] result_bits_cycles,
    output logic             result_val,
    input  logic             result_rdy
);

    localparam int KW = k_width(W);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [KW-1:0]    r_k;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_result;

    logic [W-1:0]     w_a_nxt;
    logic [W-1:0]     w_b_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_done;
    logic [W-1:0]     w_result;

    gcd_stein_step #(
        .W  (W),
        .KW (KW)
    ) u_step (
        .a      (r_a),
        .b      (r_b),
        .k      (r_k),
        .a_nxt  (w_a_nxt),
        .b_nxt  (w_b_nxt),
        .k_nxt  (w_k_nxt),
        .done   (w_done),
        .result (w_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (operands_val) w_state_nxt = CALC;
            CALC: if (w_done)       w_state_nxt = DONE;
            DONE: if (result_rdy)   w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (operands_val) begin
                        r_a   <= operands_bits_A;
                        r_b   <= operands_bits_B;
                        r_tag <= operands_bits_tag;
                        r_k   <= '0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                    r_k <= w_k_nxt;
                    if (w_done) r_result <= w_result;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode from state alone: no val->rdy paths.
    assign operands_rdy       = (r_state == IDLE);
    assign result_val         = (r_state == DONE);
    assign result_bits_data   = r_result;
    assign result_bits_tag    = r_tag;
    assign result_bits_cycles = r_cnt;

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Directed and randomised checks for gcd_stein_unit at W=16.
module tb_gcd_stein_unit;

    localparam int W     = 16;
    localparam int TAG_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [TAG_W-1:0] op_tag;
    logic             op_val;
    logic             op_rdy;
    logic [W-1:0]     res_data;
    logic [TAG_W-1:0] res_tag;
    logic [CNT_W-1:0] res_cyc;
    logic             res_val;
    logic             res_rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stein_unit #(
        .W     (W),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .reset              (rst_n),
        .operands_bits_A    (op_a),
        .operands_bits_B    (op_b),
        .operands_bits_tag  (op_tag),
        .operands_val       (op_val),
        .operands_rdy       (op_rdy),
        .result_bits_data   (res_data),
        .result_bits_tag    (res_tag),
        .result_bits_cycles (res_cyc),
        .result_val         (res_val),
        .result_rdy         (res_rdy)
    );

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Present one request, wait for result_val; optionally fire the result.
    task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TAG_W-1:0] tag, input bit release_res,
                           output int lat);
        @(negedge clk);
        op_a   = a;
        op_b   = b;
        op_tag = tag;
        op_val = 1'b1;
        @(posedge clk);
        #1;
        op_val = 1'b0;
        lat = 0;
        do begin
            if (lat > 0) begin
                @(posedge clk);
                #1;
            end
            lat++;
        end while (!res_val && lat < 200);
        if (!res_val) lat = -1;
        if (release_res) begin
            res_rdy = 1'b1;
            @(posedge clk);
            #1;
            res_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        op_val  = 1'b0;
        op_a    = '0;
        op_b    = '0;
        op_tag  = '0;
        res_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({op_rdy, res_val, res_data, res_tag, res_cyc} !==
            {1'b1, 1'b0, 16'h0, 4'h0, 8'h0}) begin
            errors++;
            $display("FAIL reset: rdy=%b val=%b data=%h tag=%h cyc=%0d",
                     op_rdy, res_val, res_data, res_tag, res_cyc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_req(16'd12, 16'd8, 4'd3, 1'b0, lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 7", lat);
        end
        checks++;
        if ({res_data, res_tag, res_cyc} !== {16'd4, 4'd3, 8'd6}) begin
            errors++;
            $display("FAIL basic_result: data=%0d tag=%0d cyc=%0d want 4 3 6",
                     res_data, res_tag, res_cyc);
        end
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        checks++;
        if ({op_rdy, res_val} !== 2'b10) begin
            errors++;
            $display("FAIL basic_idle: rdy=%b val=%b want 1 0", op_rdy, res_val);
        end
    endtask

    task automatic test_zero();
        logic [W-1:0] va [3] = '{16'd0, 16'd0, 16'd9};
        logic [W-1:0] vb [3] = '{16'd5, 16'd0, 16'd0};
        logic [W-1:0] ve [3] = '{16'd5, 16'd0, 16'd9};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_req(va[i], vb[i], 4'(i + 1), 1'b0, lat);
            checks++;
            if (lat !== 2 || res_data !== ve[i] || res_cyc !== 8'd1 ||
                res_tag !== 4'(i + 1)) begin
                errors++;
                $display("FAIL zero_%0d: lat=%0d data=%0d cyc=%0d tag=%0d want 2 %0d 1 %0d",
                         i, lat, res_data, res_cyc, res_tag, ve[i], i + 1);
            end
            res_rdy = 1'b1;
            @(posedge clk);
            #1;
            res_rdy = 1'b0;
        end
    endtask

    task automatic test_max();
        int lat;
        run_req(16'hFFFF, 16'hFFFF, 4'hF, 1'b1, lat);
        checks++;
        if (lat !== 3 || res_data !== 16'hFFFF || res_cyc !== 8'd2 ||
            res_tag !== 4'hF) begin
            errors++;
            $display("FAIL max: lat=%0d data=%h cyc=%0d tag=%h want 3 ffff 2 f",
                     lat, res_data, res_cyc, res_tag);
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad = 0;
        run_req(16'd12, 16'd8, 4'd5, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_val = i[0];
            op_a   = 16'd100;
            op_b   = 16'd7;
            op_tag = 4'd9;
            @(posedge clk);
            #1;
            if ({res_val, op_rdy, res_data, res_tag, res_cyc} !==
                {1'b1, 1'b0, 16'd4, 4'd5, 8'd6}) bad++;
        end
        op_val = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d of 10 cycles changed, data=%0d tag=%0d",
                     bad, res_data, res_tag);
        end
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        checks++;
        if ({op_rdy, res_val} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: rdy=%b val=%b want 1 0", op_rdy, res_val);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk);
        op_a   = 16'h8000;
        op_b   = 16'h0003;
        op_tag = 4'd7;
        op_val = 1'b1;
        @(posedge clk);
        #1;
        op_val = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({op_rdy, res_val, res_data, res_tag, res_cyc} !==
            {1'b1, 1'b0, 16'h0, 4'h0, 8'h0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b val=%b data=%h tag=%h cyc=%0d",
                     op_rdy, res_val, res_data, res_tag, res_cyc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_req(16'd6, 16'd4, 4'd9, 1'b1, lat);
        checks++;
        if (lat !== 6 || res_data !== 16'd2 || res_tag !== 4'd9 ||
            res_cyc !== 8'd5) begin
            errors++;
            $display("FAIL after_reset: lat=%0d data=%0d tag=%0d cyc=%0d want 6 2 9 5",
                     lat, res_data, res_tag, res_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] a, b, exp;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) a = a & 16'hFF00;
            exp = euclid(a, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_req(a, b, 4'(i), 1'b0, lat);
            checks++;
            if (lat < 2 || res_data !== exp || res_tag !== 4'(i) ||
                res_cyc > 8'(2 * W + 1) || lat !== int'(res_cyc) + 1) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h data=%h want %h tag=%0d cyc=%0d lat=%0d",
                         i, a, b, res_data, exp, res_tag, res_cyc, lat);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(negedge clk);
            res_rdy = 1'b1;
            @(posedge clk);
            #1;
            res_rdy = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
